key_debounce_array: RTL and testbench

//  Parametrised N-channel push-button debouncer for board keys feeding the game FSM.
//  - Synchronises raw key inputs, then filters them with per-channel stability counters

---
 rtl/key_debounce_array_if.sv | 24 ++
 rtl/key_debounce_array.sv | 171 +++++++++++++++++
 tb/tb_key_debounce_array.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_array_if.sv
// Key debouncer port bundle: raw keys in, debounced levels/pulses/code out.
// master = debouncer side, slave = consumer (game FSM) side.
interface key_debounce_array_if #(
  parameter int N = 4
) ();
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  keys_raw;
  logic [N-1:0]  key_level;
  logic [N-1:0]  key_press;
  logic [N-1:0]  key_release;
  logic [CW-1:0] key_code;
  logic          key_valid;

  modport master (
    input  keys_raw,
    output key_level, key_press, key_release, key_code, key_valid
  );

  modport slave (
    output keys_raw,
    input  key_level, key_press, key_release, key_code, key_valid
  );
endinterface

// File: rtl/key_debounce_array.sv
// N-channel key debouncer: 2-FF sync, tick-sampled stability counters, press/release pulses; DEB_REPEAT_EN adds auto-repeat.
// Latency: raw step -> key_level within 2 + STABLE*2**TICK_DIV clocks; key_press/key_release one clock after key_level.
// Backpressure: none; levels and single-cycle pulses are free-running and must be consumed as they appear.
module key_debounce_array #(
  parameter int N         = 4,
  parameter int TICK_DIV  = 21,
  parameter int STABLE    = 3,
  parameter int EXCLUSIVE = 1,
  parameter int RPT_DELAY = 24,
  parameter int RPT_RATE  = 6
) (
  input logic                 VGA_CLK,
  input logic                 reset,
  key_debounce_array_if.master kif
);

  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = 4;

  if (N < 1 || N > 16) begin : g_bad_n
    $error("key_debounce_array: N must be in 1..16");
  end
  if (STABLE < 1 || STABLE > 15) begin : g_bad_stable
    $error("key_debounce_array: STABLE must be in 1..15");
  end
  if (TICK_DIV < 1) begin : g_bad_tick
    $error("key_debounce_array: TICK_DIV must be at least 1");
  end
  if (RPT_DELAY < 1 || RPT_DELAY > 255 || RPT_RATE < 1 || RPT_RATE > 255) begin : g_bad_rpt
    $error("key_debounce_array: RPT_DELAY and RPT_RATE must be in 1..255");
  end

  logic [N-1:0]        sync1, sync2;
  logic [N-1:0]        samp, others;
  logic [N-1:0]        level, level_d;
  logic [N-1:0]        flip;
  logic [N-1:0]        press_q, release_q;
  logic [N-1:0]        rpt_hit;
  logic [CNTW-1:0]     cnt [N];
  logic [TICK_DIV-1:0] tick_cnt;
  logic                tick;
  logic [CW-1:0]       key_code_w;

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= kif.keys_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = &tick_cnt;

  // In exclusive mode a key only counts as pressed while it is the sole key down.
  always_comb begin
    samp   = sync2;
    others = '0;
    if (EXCLUSIVE != 0) begin
      for (int i = 0; i < N; i++) begin
        others    = sync2;
        others[i] = 1'b0;
        samp[i]   = sync2[i] & ~(|others);
      end
    end
  end

  always_comb begin
    flip = '0;
    for (int i = 0; i < N; i++) begin
      flip[i] = tick && (samp[i] != level[i]) && (cnt[i] == CNTW'(STABLE - 1));
    end
  end

  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      level <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < N; i++) begin
        if (samp[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          level[i] <= samp[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef DEB_REPEAT_EN
  logic [7:0]   rpt_cnt [N];
  logic [7:0]   rpt_inc [N];
  logic [N-1:0] rpt_arm;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      rpt_inc[i] = (rpt_cnt[i] == 8'hFF) ? 8'hFF : rpt_cnt[i] + 8'd1;
    end
  end

  // First period runs to RPT_DELAY, after that the counter re-arms on RPT_RATE.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      rpt_arm <= '0;
      rpt_hit <= '0;
      for (int i = 0; i < N; i++) begin
        rpt_cnt[i] <= '0;
      end
    end else begin
      rpt_hit <= '0;
      for (int i = 0; i < N; i++) begin
        if (!level[i] || flip[i]) begin
          rpt_cnt[i] <= '0;
          rpt_arm[i] <= 1'b0;
        end else if (tick) begin
          if (rpt_inc[i] == (rpt_arm[i] ? 8'(RPT_RATE) : 8'(RPT_DELAY))) begin
            rpt_hit[i] <= 1'b1;
            rpt_arm[i] <= 1'b1;
            rpt_cnt[i] <= '0;
          end else begin
            rpt_cnt[i] <= rpt_inc[i];
          end
        end
      end
    end
  end
`else
  assign rpt_hit = '0;
`endif

  // Press is gated by level so a press can never share a cycle with a release.
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      level_d   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      level_d   <= level;
      press_q   <= level & (~level_d | rpt_hit);
      release_q <= ~level & level_d;
    end
  end

  always_comb begin
    key_code_w = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press_q[i]) key_code_w = CW'(i);
    end
  end

  assign kif.key_level   = level;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;
  assign kif.key_code    = key_code_w;
  assign kif.key_valid   = |press_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: exclusive and non-exclusive instances share one raw key bus.
module tb_key_debounce_array;
  localparam int N  = 4;
  localparam int TD = 2;
  localparam int ST = 3;
  localparam int RD = 4;
  localparam int RR = 2;
  localparam int P  = 1 << TD;

  logic       VGA_CLK = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] raw     = 4'b0;
  bit         mon_en  = 1'b0;
  int         n_chk   = 0;
  int         n_pass  = 0;

  always #5 VGA_CLK = ~VGA_CLK;

  key_debounce_array_if #(.N(N)) kx ();
  key_debounce_array_if #(.N(N)) kn ();

  assign kx.keys_raw = raw;
  assign kn.keys_raw = raw;

  key_debounce_array #(.N(N), .TICK_DIV(TD), .STABLE(ST), .EXCLUSIVE(1),
                       .RPT_DELAY(RD), .RPT_RATE(RR)) dut_x (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .kif     (kx)
  );

  key_debounce_array #(.N(N), .TICK_DIV(TD), .STABLE(ST), .EXCLUSIVE(0),
                       .RPT_DELAY(RD), .RPT_RATE(RR)) dut_n (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .kif     (kn)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    casez (v)
      4'b???1: lowest = 2'd0;
      4'b??10: lowest = 2'd1;
      4'b?100: lowest = 2'd2;
      4'b1000: lowest = 2'd3;
      default: lowest = 2'd0;
    endcase
  endfunction

  // Reference model: index 0 = exclusive instance, 1 = non-exclusive instance.
  logic [3:0] m_s1, m_s2;
  logic [3:0] m_lvl [2];
  logic [3:0] ev_rise [2], ev_fall [2], ev_rpt [2];
  logic [3:0] e_press [2], e_rel [2];
  logic [3:0] smp [2];
  int         m_cyc;
  int         m_dis  [2][4];
  int         m_held [2][4];
  bit         tk, flp;

  always @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_cyc = 0;
      for (int d = 0; d < 2; d++) begin
        m_lvl[d] = '0; ev_rise[d] = '0; ev_fall[d] = '0; ev_rpt[d] = '0;
        e_press[d] = '0; e_rel[d] = '0;
        for (int i = 0; i < 4; i++) begin
          m_dis[d][i] = 0; m_held[d][i] = 0;
        end
      end
    end else begin
      tk = (m_cyc % P) == (P - 1);
      m_cyc++;
      for (int d = 0; d < 2; d++) begin
        e_press[d] = ev_rise[d] | ev_rpt[d];
        e_rel[d]   = ev_fall[d];
        ev_rise[d] = '0; ev_fall[d] = '0; ev_rpt[d] = '0;
      end
      smp[1] = m_s2;
      for (int i = 0; i < 4; i++) smp[0][i] = m_s2[i] && ($countones(m_s2) == 1);
      if (tk) begin
        for (int d = 0; d < 2; d++) begin
          for (int i = 0; i < 4; i++) begin
            flp = (smp[d][i] != m_lvl[d][i]) && (m_dis[d][i] + 1 >= ST);
            if (smp[d][i] == m_lvl[d][i] || flp) m_dis[d][i] = 0;
            else m_dis[d][i]++;
            if (flp) begin
              m_lvl[d][i] = smp[d][i];
              if (smp[d][i]) ev_rise[d][i] = 1'b1;
              else ev_fall[d][i] = 1'b1;
              m_held[d][i] = 0;
            end else if (m_lvl[d][i]) begin
              m_held[d][i]++;
`ifdef DEB_REPEAT_EN
              if (m_held[d][i] == RD || (m_held[d][i] > RD && (m_held[d][i] - RD) % RR == 0))
                ev_rpt[d][i] = 1'b1;
`endif
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  end

  task automatic chk_dut(input string p, input int d, input logic [3:0] lvl, input logic [3:0] prs,
                         input logic [3:0] rel, input logic [1:0] code, input logic vld);
    check({p, "_level"},   lvl,  m_lvl[d]);
    check({p, "_press"},   prs,  e_press[d]);
    check({p, "_release"}, rel,  e_rel[d]);
    check({p, "_code"},    code, lowest(e_press[d]));
    check({p, "_valid"},   vld,  |e_press[d]);
    check({p, "_press_and_release"}, prs & rel, 4'b0);
  endtask

  always @(negedge VGA_CLK) begin
    if (reset && mon_en) begin
      chk_dut("mx", 0, kx.key_level, kx.key_press, kx.key_release, kx.key_code, kx.key_valid);
      chk_dut("mn", 1, kn.key_level, kn.key_press, kn.key_release, kn.key_code, kn.key_valid);
    end
  end

  typedef struct {
    logic [3:0] raw;
    int         hold;
    logic [3:0] pm_n;
    int         np_n;
    int         nr_n;
    logic [1:0] code_n;
    logic [3:0] pm_x;
    int         np_x;
    int         nr_x;
  } vec_t;

  vec_t tbl [6];

  task automatic idle(input int n);
    raw = 4'b0;
    repeat (n) @(negedge VGA_CLK);
  endtask

  task automatic all_zero(input string p);
    check({p, "_x_out"}, {kx.key_level, kx.key_press, kx.key_release, kx.key_code, kx.key_valid}, 0);
    check({p, "_n_out"}, {kn.key_level, kn.key_press, kn.key_release, kn.key_code, kn.key_valid}, 0);
  endtask

  initial begin
    int         lat, p1, np_n, nr_n, np_x, nr_x;
    logic [3:0] pm_n, pm_x;
    logic [1:0] code_n;
    bit         got_code;
    logic [63:0] seen, exp_seen;

    tbl[0] = '{4'b0001, 12, 4'b0001, 1, 1, 2'd0, 4'b0001, 1, 1};
    tbl[1] = '{4'b0110, 12, 4'b0110, 2, 2, 2'd1, 4'b0000, 0, 0};
    tbl[2] = '{4'b0100,  4, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 0};
    tbl[3] = '{4'b1000, 12, 4'b1000, 1, 1, 2'd3, 4'b1000, 1, 1};
    tbl[4] = '{4'b1111, 12, 4'b1111, 4, 4, 2'd0, 4'b0000, 0, 0};
    tbl[5] = '{4'b1010,  2, 4'b0000, 0, 0, 2'd0, 4'b0000, 0, 0};

    @(negedge VGA_CLK);
    #1 all_zero("reset_state");
    repeat (2) @(negedge VGA_CLK);
    #2 reset = 1'b1;
    mon_en = 1'b1;
    idle(8);

    // Async reset while a key is debounced, then re-acquire from scratch.
    raw = 4'b0010;
    lat = 0;
    while (kx.key_level !== 4'b0010 && lat < 20) begin @(negedge VGA_CLK); lat++; end
    check("t1_pre_level", kx.key_level, 4'b0010);
    @(posedge VGA_CLK);
    #2 reset = 1'b0;
    #1 all_zero("t1_async_reset");
    @(negedge VGA_CLK);
    #2 reset = 1'b1;
    lat = 0;
    while (kx.key_level[1] !== 1'b1 && lat < 30) begin @(negedge VGA_CLK); lat++; end
    check("t1_relatch_clocks", lat, 12);
    idle(30);

    // Single key: latency bound and one-cycle press pulse.
    raw = 4'b0001;
    lat = 0;
    while (kn.key_level[0] !== 1'b1 && lat < 20) begin @(negedge VGA_CLK); lat++; end
    n_chk++;
    if (lat >= 11 && lat <= 14) n_pass++;
    else $display("FAIL t2_latency: got %0d clocks, want 11..14", lat);
    @(negedge VGA_CLK);
    check("t2_press", kn.key_press, 4'b0001);
    check("t2_code", kn.key_code, 2'd0);
    check("t2_valid", kn.key_valid, 1'b1);
    raw = 4'b0;
    @(negedge VGA_CLK);
    check("t2_press_gone", kn.key_press, 4'b0000);
    check("t2_valid_gone", kn.key_valid, 1'b0);
    idle(30);

    // Table: pattern held for 'hold' clocks then released, 32 clocks per row.
    for (int v = 0; v < 6; v++) begin
      pm_n = '0; pm_x = '0; np_n = 0; nr_n = 0; np_x = 0; nr_x = 0;
      code_n = '0; got_code = 1'b0;
      raw = tbl[v].raw;
      for (int c = 0; c < 32; c++) begin
        if (c == tbl[v].hold) raw = 4'b0;
        @(negedge VGA_CLK);
        pm_n |= kn.key_press; pm_x |= kx.key_press;
        np_n += $countones(kn.key_press); nr_n += $countones(kn.key_release);
        np_x += $countones(kx.key_press); nr_x += $countones(kx.key_release);
        if (kn.key_valid && !got_code) begin code_n = kn.key_code; got_code = 1'b1; end
      end
      check($sformatf("tbl%0d_pmask_n", v), pm_n, tbl[v].pm_n);
      check($sformatf("tbl%0d_npress_n", v), np_n, tbl[v].np_n);
      check($sformatf("tbl%0d_nrel_n", v), nr_n, tbl[v].nr_n);
      if (tbl[v].np_n > 0) check($sformatf("tbl%0d_code_n", v), code_n, tbl[v].code_n);
      check($sformatf("tbl%0d_pmask_x", v), pm_x, tbl[v].pm_x);
      check($sformatf("tbl%0d_npress_x", v), np_x, tbl[v].np_x);
      check($sformatf("tbl%0d_nrel_x", v), nr_x, tbl[v].nr_x);
    end

    // Bounce on key 2: 1,0 for one tick each, then stable.
    np_n = 0; nr_n = 0;
    for (int s = 0; s < 4; s++) begin
      raw = (s == 0 || s == 2) ? 4'b0100 : 4'b0000;
      repeat ((s == 2) ? 12 : (s == 3) ? 20 : 4) begin
        @(negedge VGA_CLK);
        np_n += int'(kn.key_press[2]);
        nr_n += int'(kn.key_release[2]);
      end
    end
    check("t3_bounce_presses", np_n, 1);
    check("t3_bounce_releases", nr_n, 1);
    idle(8);

    // Exclusive: held key 3 is dropped once key 1 joins it.
    raw = 4'b1000;
    lat = 0;
    while (kx.key_level[3] !== 1'b1 && lat < 20) begin @(negedge VGA_CLK); lat++; end
    check("t5_key3_up", kx.key_level[3], 1'b1);
    raw = 4'b1010;
    lat = 0; p1 = 0;
    while (kx.key_release[3] !== 1'b1 && lat < 30) begin
      @(negedge VGA_CLK); lat++; p1 += int'(kx.key_press[1]);
    end
    check("t5_release3_clocks", lat, 13);
    repeat (10) begin @(negedge VGA_CLK); p1 += int'(kx.key_press[1]); end
    check("t5_no_press1", p1, 0);
    idle(40);

    // Long hold on key 0: repeat pulses only when the repeat feature is built in.
    raw = 4'b0001;
    lat = 0;
    while (kn.key_press[0] !== 1'b1 && lat < 20) begin @(negedge VGA_CLK); lat++; end
    check("t6_first_press", kn.key_press[0], 1'b1);
    seen = '0;
    for (int c = 1; c <= 52; c++) begin
      @(negedge VGA_CLK);
      if (kn.key_press[0]) seen[c] = 1'b1;
    end
`ifdef DEB_REPEAT_EN
    exp_seen = (64'd1 << 16) | (64'd1 << 24) | (64'd1 << 32) | (64'd1 << 40) | (64'd1 << 48);
`else
    exp_seen = 64'd0;
`endif
    check("t6_repeat_slots", seen, exp_seen);
    idle(40);

    // Random key activity, checked cycle by cycle against the model.
    for (int s = 0; s < 70; s++) begin
      if ($urandom_range(0, 1) == 1) raw = 4'b0001 << $urandom_range(0, 3);
      else raw = 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 30)) @(negedge VGA_CLK);
    end
    idle(40);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end
endmodule
